// File: rtl/pipe_line_r4_stage.sv
// pipe_line_r4_stage: radix-4 FFT pipeline stage (twiddle multiply, forward/inverse butterfly, scale, saturate, reserialise)
// Ports: clk; rst (async, active-low); in_valid/in_sync qualify in_data {re,im} and in_omega {re,im};
//        in_inverse and in_scale are taken with x0; out_valid/out_first qualify out_data {re,im}, X0..X3 in order.
module pipe_line_r4_stage #(
  parameter int WORDLENGTH_IO = 16,
  parameter int WORDLENGTH_WP = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_sync,
  input  logic [2*WORDLENGTH_IO-1:0]   in_data,
  input  logic [2*WORDLENGTH_WP-1:0]   in_omega,
  input  logic                         in_inverse,
  input  logic [1:0]                   in_scale,
  output logic                         out_valid,
  output logic                         out_first,
  output logic [2*WORDLENGTH_IO-1:0]   out_data
);
  localparam int IO = WORDLENGTH_IO;
  localparam int WP = WORDLENGTH_WP;
  localparam int PW = IO + WP + 1;
  localparam int MW = IO + 1;
  // one spare bit over the IO+3 butterfly range keeps the rounding add from wrapping
  localparam int SW = IO + 4;
  localparam logic signed [SW-1:0] SMAX = SW'((1 << (IO - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

  function automatic logic [2*MW-1:0] cmul(input logic [2*IO-1:0] x, input logic [2*WP-1:0] w);
    logic signed [PW-1:0] xr, xi, wr, wi, pr, pi;
    xr = PW'($signed(x[2*IO-1:IO]));
    xi = PW'($signed(x[IO-1:0]));
    wr = PW'($signed(w[2*WP-1:WP]));
    wi = PW'($signed(w[WP-1:0]));
    pr = xr * wr - xi * wi + PW'(1 << (WP - 3));
    pi = xr * wi + xi * wr + PW'(1 << (WP - 3));
    return {MW'(pr >>> (WP - 2)), MW'(pi >>> (WP - 2))};
  endfunction

  function automatic logic [IO-1:0] scale_sat(input logic signed [SW-1:0] v, input logic [1:0] s);
    logic signed [SW-1:0] rnd, r;
    rnd = s == 2'd2 ? SW'(2) : s == 2'd1 ? SW'(1) : SW'(0);
    r = (v + rnd) >>> s;
    return r > SMAX ? IO'(SMAX) : r < SMIN ? IO'(SMIN) : IO'(r);
  endfunction

  logic [1:0]                 cnt_q, cnt_d, idx;
  logic [3:0][2*IO-1:0]       x_q, x_d;
  logic [3:1][2*WP-1:0]       w_q, w_d;
  logic                       inv_q, inv_d, go0_q, go0_d;
  logic [1:0]                 scl_q, scl_d;
  logic [2*IO-1:0]            m_a_q, m_a_d;
  logic [2*MW-1:0]            m_b_q, m_b_d, m_c_q, m_c_d, m_d_q, m_d_d;
  logic                       m_inv_q, m_inv_d, go1_q, go1_d;
  logic [1:0]                 m_scl_q, m_scl_d;
  logic [3:0][2*IO-1:0]       b_q, b_d;
  logic                       go2_q, go2_d;
  logic [1:0]                 e_idx_q, e_idx_d;
  logic                       e_act_q, e_act_d;
  logic                       out_valid_q, out_valid_d, out_first_q, out_first_d;
  logic [2*IO-1:0]            out_data_q, out_data_d;
  logic signed [SW-1:0]       ar, ai, br, bi, cr, ci, dr, di, jr, ji;

  // sync realigns the write index to x0; a partial group is simply overwritten
  always_comb begin
    idx = in_sync ? 2'd0 : cnt_q;
    cnt_d = in_valid ? idx + 2'd1 : cnt_q;
    go0_d = in_valid & (idx == 2'd3);
    x_d = x_q;
    w_d = w_q;
    if (in_valid) x_d[idx] = in_data;
    for (int i = 1; i < 4; i++) if (in_valid && idx == 2'(i)) w_d[i] = in_omega;
    inv_d = in_valid && idx == 2'd0 ? in_inverse : inv_q;
    scl_d = in_valid && idx == 2'd0 ? (in_scale == 2'd3 ? 2'd2 : in_scale) : scl_q;
  end

  // mode and scale travel with the group so a following x0 cannot disturb it
  always_comb begin
    m_a_d = go0_q ? x_q[0] : m_a_q;
    m_b_d = go0_q ? cmul(x_q[1], w_q[1]) : m_b_q;
    m_c_d = go0_q ? cmul(x_q[2], w_q[2]) : m_c_q;
    m_d_d = go0_q ? cmul(x_q[3], w_q[3]) : m_d_q;
    m_inv_d = go0_q ? inv_q : m_inv_q;
    m_scl_d = go0_q ? scl_q : m_scl_q;
    go1_d = go0_q;
  end

  // jr/ji carry the +-j terms: X1 and X3 differ only in their sign, swapped for inverse
  always_comb begin
    ar = SW'($signed(m_a_q[2*IO-1:IO]));
    ai = SW'($signed(m_a_q[IO-1:0]));
    br = SW'($signed(m_b_q[2*MW-1:MW]));
    bi = SW'($signed(m_b_q[MW-1:0]));
    cr = SW'($signed(m_c_q[2*MW-1:MW]));
    ci = SW'($signed(m_c_q[MW-1:0]));
    dr = SW'($signed(m_d_q[2*MW-1:MW]));
    di = SW'($signed(m_d_q[MW-1:0]));
    jr = m_inv_q ? di - bi : bi - di;
    ji = m_inv_q ? dr - br : br - dr;
    b_d = b_q;
    if (go1_q) begin
      b_d[0] = {scale_sat(ar + br + cr + dr, m_scl_q), scale_sat(ai + bi + ci + di, m_scl_q)};
      b_d[1] = {scale_sat(ar - cr + jr, m_scl_q), scale_sat(ai - ci - ji, m_scl_q)};
      b_d[2] = {scale_sat(ar - br + cr - dr, m_scl_q), scale_sat(ai - bi + ci - di, m_scl_q)};
      b_d[3] = {scale_sat(ar - cr - jr, m_scl_q), scale_sat(ai - ci + ji, m_scl_q)};
    end
    go2_d = go1_q;
  end

  // the butterfly bank stays stable for the whole emission since groups are >= 4 cycles apart
  always_comb begin
    out_data_d = go2_q ? b_q[0] : e_act_q ? b_q[e_idx_q] : out_data_q;
    out_valid_d = go2_q | e_act_q;
    out_first_d = go2_q;
    e_idx_d = go2_q ? 2'd1 : e_idx_q + 2'd1;
    e_act_d = go2_q | (e_act_q & (e_idx_q != 2'd3));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      x_q         <= '0;
      w_q         <= '0;
      inv_q       <= 1'b0;
      scl_q       <= '0;
      go0_q       <= 1'b0;
      m_a_q       <= '0;
      m_b_q       <= '0;
      m_c_q       <= '0;
      m_d_q       <= '0;
      m_inv_q     <= 1'b0;
      m_scl_q     <= '0;
      go1_q       <= 1'b0;
      b_q         <= '0;
      go2_q       <= 1'b0;
      e_idx_q     <= '0;
      e_act_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      w_q         <= w_d;
      inv_q       <= inv_d;
      scl_q       <= scl_d;
      go0_q       <= go0_d;
      m_a_q       <= m_a_d;
      m_b_q       <= m_b_d;
      m_c_q       <= m_c_d;
      m_d_q       <= m_d_d;
      m_inv_q     <= m_inv_d;
      m_scl_q     <= m_scl_d;
      go1_q       <= go1_d;
      b_q         <= b_d;
      go2_q       <= go2_d;
      e_idx_q     <= e_idx_d;
      e_act_q     <= e_act_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_pipe_line_r4_stage.sv
// tb_pipe_line_r4_stage: randomized and directed bench for the radix-4 stage against a DFT-style reference model
module tb_pipe_line_r4_stage;
  localparam int IO = 16;
  localparam int WP = 9;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_sync = 1'b0;
  logic in_inverse = 1'b0;
  logic [1:0] in_scale = 2'd0;
  logic [2*IO-1:0] in_data = '0;
  logic [2*WP-1:0] in_omega = '0;
  logic out_valid, out_first;
  logic [2*IO-1:0] out_data;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_x3 = 0;
  typedef struct {
    logic first;
    logic [2*IO-1:0] data;
    int cyc;
  } rec_t;
  rec_t cap[$];
  logic [2*IO-1:0] exp_q[$];

  pipe_line_r4_stage #(.WORDLENGTH_IO(IO), .WORDLENGTH_WP(WP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
    .in_omega(in_omega), .in_inverse(in_inverse), .in_scale(in_scale),
    .out_valid(out_valid), .out_first(out_first), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (out_valid === 1'b1) cap.push_back('{out_first, out_data, cyc});

  function automatic logic [31:0] cx(input int r, input int i);
    return {16'(r), 16'(i)};
  endfunction

  function automatic logic [17:0] cw(input int r, input int i);
    return {9'(r), 9'(i)};
  endfunction

  function automatic longint wrap(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v & (m - 1);
    return r >= (m >> 1) ? r - m : r;
  endfunction

  function automatic longint clamp(input longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  // X_k = sum_n y_n * j^(-+nk), y_0 = x_0, y_n = rounded twiddle product held at IO+1 bits
  task automatic model(input logic [3:0][31:0] xs, input logic [3:0][17:0] ws, input bit inv, input logic [1:0] sc);
    longint yr[4], yi[4], xr, xi, wr, wi, sr, si, r, q;
    int s, m;
    s = sc > 2'd2 ? 2 : int'(sc);
    for (int n = 0; n < 4; n++) begin
      xr = longint'($signed(xs[n][31:16]));
      xi = longint'($signed(xs[n][15:0]));
      wr = longint'($signed(ws[n][17:9]));
      wi = longint'($signed(ws[n][8:0]));
      yr[n] = n == 0 ? xr : wrap((xr * wr - xi * wi + (1 << (WP - 3))) >>> (WP - 2), IO + 1);
      yi[n] = n == 0 ? xi : wrap((xr * wi + xi * wr + (1 << (WP - 3))) >>> (WP - 2), IO + 1);
    end
    for (int k = 0; k < 4; k++) begin
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        m = inv ? (n * k) % 4 : (4 - (n * k) % 4) % 4;
        case (m)
          0: begin r = yr[n]; q = yi[n]; end
          1: begin r = -yi[n]; q = yr[n]; end
          2: begin r = -yr[n]; q = -yi[n]; end
          default: begin r = yi[n]; q = -yr[n]; end
        endcase
        sr += r;
        si += q;
      end
      if (s > 0) begin
        sr = (sr + (longint'(1) << (s - 1))) >>> s;
        si = (si + (longint'(1) << (s - 1))) >>> s;
      end
      sr = clamp(sr);
      si = clamp(si);
      exp_q.push_back({16'(sr), 16'(si)});
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put(input logic [31:0] d, input logic [17:0] w, input bit sync, input bit inv, input logic [1:0] sc);
    in_valid = 1'b1;
    in_sync = sync;
    in_data = d;
    in_omega = w;
    in_inverse = inv;
    in_scale = sc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sync = 1'b0;
  endtask

  // mode/scale are only meaningful on x0; later samples carry random junk there
  task automatic send_group(input logic [3:0][31:0] xs, input logic [3:0][17:0] ws, input bit inv, input logic [1:0] sc, input int gp);
    model(xs, ws, inv, sc);
    for (int n = 0; n < 4; n++) begin
      if (gp > 0 && $urandom_range(0, 1) == 1) gap($urandom_range(1, gp));
      if (n == 0) put(xs[n], ws[n], 1'b1, inv, sc);
      else put(xs[n], ws[n], 1'b0, 1'($urandom), 2'($urandom));
    end
    last_x3 = cyc;
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 200 && cap.size() < n; t++) begin @(posedge clk); #1; end
    gap(6);
  endtask

  task automatic start();
    cap.delete();
    exp_q.delete();
  endtask

  function automatic logic [3:0][17:0] unit_w();
    return {4{cw(128, 0)}};
  endfunction

  function automatic logic [3:0][31:0] rand_x();
    logic [3:0][31:0] xs;
    for (int n = 0; n < 4; n++) xs[n] = $urandom;
    return xs;
  endfunction

  function automatic logic [3:0][17:0] rand_w();
    logic [3:0][17:0] ws;
    for (int n = 0; n < 4; n++) ws[n] = 18'($urandom);
    return ws;
  endfunction

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++;
    if (out_first !== 1'b0) begin bad++; $display("FAIL reset_first got=%b want=0", out_first); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
  endtask

  task automatic test_impulse();
    logic [3:0][31:0] xs;
    int lat;
    start();
    xs = '0;
    xs[0] = cx(100, 0);
    send_group(xs, unit_w(), 1'b0, 2'd0, 0);
    wait_out(4);
    total++;
    if (cap.size() != 4) begin bad++; $display("FAIL impulse_count got=%0d want=4", cap.size()); end
    for (int i = 0; i < cap.size() && i < 4; i++) begin
      total++;
      if (cap[i].data !== cx(100, 0) || cap[i].first !== (i == 0)) begin
        bad++; $display("FAIL impulse_X%0d got=%h/%b want=%h/%b", i, cap[i].data, cap[i].first, cx(100, 0), i == 0);
      end
    end
    lat = cap.size() > 0 ? cap[0].cyc - last_x3 : -1;
    total++;
    if (lat != 3) begin bad++; $display("FAIL impulse_latency got=%0d want=3", lat); end
  endtask

  task automatic test_dc_scale();
    logic [3:0][31:0] xs, want;
    logic [1:0] sc;
    for (int t = 0; t < 3; t++) begin
      sc = t == 0 ? 2'd0 : t == 1 ? 2'd2 : 2'd3;
      start();
      xs = {4{cx(1000, 0)}};
      want = '0;
      want[0] = sc == 2'd0 ? cx(4000, 0) : cx(1000, 0);
      send_group(xs, unit_w(), 1'b0, sc, 0);
      wait_out(4);
      total++;
      if (cap.size() != 4) begin bad++; $display("FAIL dc_s%0d_count got=%0d want=4", sc, cap.size()); end
      for (int i = 0; i < cap.size() && i < 4; i++) begin
        total++;
        if (cap[i].data !== want[i] || cap[i].first !== (i == 0)) begin
          bad++; $display("FAIL dc_s%0d_X%0d got=%h/%b want=%h/%b", sc, i, cap[i].data, cap[i].first, want[i], i == 0);
        end
      end
    end
  endtask

  task automatic test_inverse_j();
    logic [3:0][31:0] xs, want;
    for (int inv = 0; inv < 2; inv++) begin
      start();
      xs = '0;
      xs[1] = cx(100, 0);
      want[0] = cx(100, 0);
      want[1] = inv == 1 ? cx(0, 100) : cx(0, -100);
      want[2] = cx(-100, 0);
      want[3] = inv == 1 ? cx(0, -100) : cx(0, 100);
      send_group(xs, unit_w(), 1'(inv), 2'd0, 0);
      wait_out(4);
      total++;
      if (cap.size() != 4) begin bad++; $display("FAIL inv%0d_count got=%0d want=4", inv, cap.size()); end
      for (int i = 0; i < cap.size() && i < 4; i++) begin
        total++;
        if (cap[i].data !== want[i]) begin
          bad++; $display("FAIL inv%0d_X%0d got=%h want=%h", inv, i, cap[i].data, want[i]);
        end
      end
    end
  endtask

  task automatic test_twiddle();
    logic [3:0][31:0] xs, want;
    logic [3:0][17:0] ws;
    start();
    xs = '0;
    xs[1] = cx(100, 0);
    ws = unit_w();
    ws[1] = cw(0, 128);
    want[0] = cx(0, 100);
    want[1] = cx(100, 0);
    want[2] = cx(0, -100);
    want[3] = cx(-100, 0);
    send_group(xs, ws, 1'b0, 2'd0, 0);
    wait_out(4);
    total++;
    if (cap.size() != 4) begin bad++; $display("FAIL twiddle_count got=%0d want=4", cap.size()); end
    for (int i = 0; i < cap.size() && i < 4; i++) begin
      total++;
      if (cap[i].data !== want[i]) begin bad++; $display("FAIL twiddle_X%0d got=%h want=%h", i, cap[i].data, want[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [3:0][31:0] xs, want;
    start();
    xs = {4{cx(30000, -30000)}};
    want = '0;
    want[0] = cx(32767, -32768);
    send_group(xs, unit_w(), 1'b0, 2'd0, 0);
    wait_out(4);
    total++;
    if (cap.size() != 4) begin bad++; $display("FAIL sat_count got=%0d want=4", cap.size()); end
    for (int i = 0; i < cap.size() && i < 4; i++) begin
      total++;
      if (cap[i].data !== want[i]) begin bad++; $display("FAIL sat_X%0d got=%h want=%h", i, cap[i].data, want[i]); end
    end
  endtask

  task automatic test_back_to_back();
    start();
    for (int g = 0; g < 3; g++) send_group(rand_x(), rand_w(), 1'($urandom), 2'($urandom), 0);
    wait_out(12);
    total++;
    if (cap.size() != 12) begin bad++; $display("FAIL b2b_count got=%0d want=12", cap.size()); end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      total++;
      if (cap[i].data !== exp_q[i] || cap[i].first !== (i % 4 == 0) || cap[i].cyc != cap[0].cyc + i) begin
        bad++; $display("FAIL b2b_%0d got=%h/%b@%0d want=%h/%b@%0d", i, cap[i].data, cap[i].first, cap[i].cyc,
                        exp_q[i], i % 4 == 0, cap[0].cyc + i);
      end
    end
  endtask

  task automatic test_random_gaps();
    start();
    for (int g = 0; g < 8; g++) send_group(rand_x(), rand_w(), 1'($urandom), 2'($urandom), 3);
    wait_out(32);
    total++;
    if (cap.size() != 32) begin bad++; $display("FAIL gaps_count got=%0d want=32", cap.size()); end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      total++;
      if (cap[i].data !== exp_q[i] || cap[i].first !== (i % 4 == 0)) begin
        bad++; $display("FAIL gaps_%0d got=%h/%b want=%h/%b", i, cap[i].data, cap[i].first, exp_q[i], i % 4 == 0);
      end
    end
  endtask

  task automatic test_sync_realign();
    start();
    put($urandom, 18'($urandom), 1'b1, 1'b0, 2'd0);
    put($urandom, 18'($urandom), 1'b0, 1'b0, 2'd0);
    send_group(rand_x(), rand_w(), 1'($urandom), 2'($urandom), 2);
    wait_out(4);
    total++;
    if (cap.size() != 4) begin bad++; $display("FAIL sync_count got=%0d want=4", cap.size()); end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      total++;
      if (cap[i].data !== exp_q[i] || cap[i].first !== (i == 0)) begin
        bad++; $display("FAIL sync_%0d got=%h/%b want=%h/%b", i, cap[i].data, cap[i].first, exp_q[i], i == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    start();
    send_group(rand_x(), rand_w(), 1'b0, 2'd1, 0);
    for (int t = 0; t < 20 && cap.size() < 2; t++) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_data !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%b/%b/%h want=0/0/0", out_valid, out_first, out_data);
    end
    gap(2);
    rst = 1'b1;
    gap(12);
    total++;
    if (cap.size() != 2) begin bad++; $display("FAIL rstmid_residual got=%0d want=2", cap.size()); end
    start();
    send_group(rand_x(), rand_w(), 1'b1, 2'd0, 1);
    wait_out(4);
    total++;
    if (cap.size() != 4) begin bad++; $display("FAIL rstmid_after_count got=%0d want=4", cap.size()); end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      total++;
      if (cap[i].data !== exp_q[i] || cap[i].first !== (i == 0)) begin
        bad++; $display("FAIL rstmid_after_%0d got=%h/%b want=%h/%b", i, cap[i].data, cap[i].first, exp_q[i], i == 0);
      end
    end
  endtask

  initial begin
    gap(3);
    test_reset();
    rst = 1'b1;
    gap(2);
    test_impulse();
    test_dc_scale();
    test_inverse_j();
    test_twiddle();
    test_saturation();
    test_back_to_back();
    test_random_gaps();
    test_sync_realign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
